// File: rtl/fan_step_scheduler.sv
// Fan controller step scheduler: paces controller steps, samples ADC/set-point
// once per step and applies double-buffered coefficient sets at step boundaries.
module fan_step_scheduler #(
    parameter int unsigned STEP_CYCLES   = 200000,
    parameter int unsigned ADC_BITWIDTH  = 4,
    parameter int unsigned COEF_BITWIDTH = 8,
    parameter int          RST_B2        = 94,
    parameter int          RST_B1        = 0,
    parameter int          RST_B0        = -93,
    parameter int          RST_A1        = 0,
    parameter int          RST_A0        = -64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic [ADC_BITWIDTH-1:0]  adc_i,
    input  logic [ADC_BITWIDTH-1:0]  set_i,
    input  logic                     cfg_valid_i,
    input  logic [2:0]               cfg_addr_i,
    input  logic [COEF_BITWIDTH-1:0] cfg_data_i,
    input  logic                     cfg_commit_i,
    output logic                     cfg_ready_o,
    output logic                     cfg_pending_o,
    output logic                     cfg_err_o,
    output logic                     step_o,
    output logic [ADC_BITWIDTH-1:0]  adc_o,
    output logic [ADC_BITWIDTH-1:0]  set_o,
    output logic [COEF_BITWIDTH-1:0] b2_o,
    output logic [COEF_BITWIDTH-1:0] b1_o,
    output logic [COEF_BITWIDTH-1:0] b0_o,
    output logic [COEF_BITWIDTH-1:0] a1_o,
    output logic [COEF_BITWIDTH-1:0] a0_o
);

    localparam int unsigned CNT_W = $clog2(STEP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(STEP_CYCLES - 2);
    localparam logic [COEF_BITWIDTH-1:0] RST_B2_V = COEF_BITWIDTH'(RST_B2);
    localparam logic [COEF_BITWIDTH-1:0] RST_B1_V = COEF_BITWIDTH'(RST_B1);
    localparam logic [COEF_BITWIDTH-1:0] RST_B0_V = COEF_BITWIDTH'(RST_B0);
    localparam logic [COEF_BITWIDTH-1:0] RST_A1_V = COEF_BITWIDTH'(RST_A1);
    localparam logic [COEF_BITWIDTH-1:0] RST_A0_V = COEF_BITWIDTH'(RST_A0);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [ADC_BITWIDTH-1:0]  adc_s1_q, adc_s2_q, set_s1_q, set_s2_q;
    logic [ADC_BITWIDTH-1:0]  adc_q, set_q;
    logic [COEF_BITWIDTH-1:0] shadow_q [5];
    logic [COEF_BITWIDTH-1:0] active_q [5];
    logic                     pending_q, pending_d;
    logic                     ready_q, err_q, step_q;
    logic                     run_c, sample_c, apply_c, step_d, wr_c;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state: ena low leaves RUN in the cycle it is seen
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ena)  state_d = RUN;
            RUN:     if (!ena) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Per-state controls: count/sample/step only while running; IDLE flushes a pending commit
    always_comb begin
        run_c    = 1'b0;
        sample_c = 1'b0;
        step_d   = 1'b0;
        apply_c  = 1'b0;
        case (state_q)
            IDLE: apply_c = pending_q;
            RUN: begin
                if (ena) begin
                    run_c    = 1'b1;
                    sample_c = (cnt_q == CNT_SAMPLE);
                    step_d   = (cnt_q == CNT_LAST);
                    apply_c  = pending_q && (cnt_q == CNT_SAMPLE);
                end
            end
            default: ;
        endcase
    end

    // Counter and commit bookkeeping
    always_comb begin
        cnt_d = '0;
        if (run_c && (cnt_q != CNT_LAST)) cnt_d = cnt_q + CNT_W'(1);
        wr_c      = cfg_valid_i && ready_q;
        pending_d = pending_q;
        if (apply_c)                        pending_d = 1'b0;
        else if (cfg_commit_i && !pending_q) pending_d = 1'b1;
    end

    // Two-flop synchronizers for the asynchronous ADC and set-point inputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            adc_s1_q <= '0;
            adc_s2_q <= '0;
            set_s1_q <= '0;
            set_s2_q <= '0;
        end else begin
            adc_s1_q <= adc_i;
            adc_s2_q <= adc_s1_q;
            set_s1_q <= set_i;
            set_s2_q <= set_s1_q;
        end
    end

    // Counter, step pulse, held samples and config status
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            step_q    <= 1'b0;
            adc_q     <= '0;
            set_q     <= '0;
            pending_q <= 1'b0;
            ready_q   <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            step_q    <= step_d;
            pending_q <= pending_d;
            ready_q   <= !pending_d;
            if (sample_c) begin
                adc_q <= adc_s2_q;
                set_q <= set_s2_q;
            end
            if (wr_c && (cfg_addr_i > 3'd4)) err_q <= 1'b1;
        end
    end

    // Shadow (write side) and active (controller side) coefficient banks
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q[0] <= RST_B2_V;
            shadow_q[1] <= RST_B1_V;
            shadow_q[2] <= RST_B0_V;
            shadow_q[3] <= RST_A1_V;
            shadow_q[4] <= RST_A0_V;
            active_q[0] <= RST_B2_V;
            active_q[1] <= RST_B1_V;
            active_q[2] <= RST_B0_V;
            active_q[3] <= RST_A1_V;
            active_q[4] <= RST_A0_V;
        end else begin
            if (wr_c) begin
                case (cfg_addr_i)
                    3'd0:    shadow_q[0] <= cfg_data_i;
                    3'd1:    shadow_q[1] <= cfg_data_i;
                    3'd2:    shadow_q[2] <= cfg_data_i;
                    3'd3:    shadow_q[3] <= cfg_data_i;
                    3'd4:    shadow_q[4] <= cfg_data_i;
                    default: ;
                endcase
            end
            // Writes are blocked while pending, so the applied set never races a write
            if (apply_c) begin
                for (int i = 0; i < 5; i++) active_q[i] <= shadow_q[i];
            end
        end
    end

    assign cfg_ready_o   = ready_q;
    assign cfg_pending_o = pending_q;
    assign cfg_err_o     = err_q;
    assign step_o        = step_q;
    assign adc_o         = adc_q;
    assign set_o         = set_q;
    assign b2_o          = active_q[0];
    assign b1_o          = active_q[1];
    assign b0_o          = active_q[2];
    assign a1_o          = active_q[3];
    assign a0_o          = active_q[4];

endmodule

// File: tb/tb_fan_step_scheduler.sv
// Self-checking bench for fan_step_scheduler with STEP_CYCLES=10.
module tb_fan_step_scheduler;

    localparam int N = 10;
    localparam logic [51:0] RESET_VEC =
        {1'b0, 4'h0, 4'h0, 8'h5E, 8'h00, 8'hA3, 8'h00, 8'hC0, 1'b0, 1'b1, 1'b0};

    logic       clk = 1'b0;
    logic       rst_n, ena, cfg_valid_i, cfg_commit_i;
    logic [3:0] adc_i, set_i;
    logic [2:0] cfg_addr_i;
    logic [7:0] cfg_data_i;
    logic       cfg_ready_o, cfg_pending_o, cfg_err_o, step_o;
    logic [3:0] adc_o, set_o;
    logic [7:0] b2_o, b1_o, b0_o, a1_o, a0_o;
    logic [51:0] dut_vec;

    int pass_cnt = 0;
    int total_cnt = 0;

    // reference model state
    bit         m_run, m_step, m_pend, m_err;
    int         m_t;
    logic [3:0] m_adc, m_set;
    logic [3:0] h_adc [2];
    logic [3:0] h_set [2];
    logic [7:0] m_sh  [5];
    logic [7:0] m_act [5];

    fan_step_scheduler #(.STEP_CYCLES(N)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .adc_i(adc_i), .set_i(set_i),
        .cfg_valid_i(cfg_valid_i), .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
        .cfg_commit_i(cfg_commit_i), .cfg_ready_o(cfg_ready_o),
        .cfg_pending_o(cfg_pending_o), .cfg_err_o(cfg_err_o), .step_o(step_o),
        .adc_o(adc_o), .set_o(set_o), .b2_o(b2_o), .b1_o(b1_o), .b0_o(b0_o),
        .a1_o(a1_o), .a0_o(a0_o)
    );

    always #5 clk = ~clk;

    assign dut_vec = {step_o, adc_o, set_o, b2_o, b1_o, b0_o, a1_o, a0_o,
                      cfg_pending_o, cfg_ready_o, cfg_err_o};

    function automatic logic [51:0] exp_vec();
        return {m_step, m_adc, m_set, m_act[0], m_act[1], m_act[2], m_act[3], m_act[4],
                m_pend, !m_pend, m_err};
    endfunction

    // Behavioural model: what the outputs must be after the coming edge.
    // m_t counts edges since entering RUN; a step falls every N edges.
    task automatic model_update();
        bit bnd, stp, apply, new_pend;
        if (!rst_n) begin
            m_run = 0; m_t = 0; m_step = 0; m_pend = 0; m_err = 0;
            m_adc = '0; m_set = '0;
            h_adc[0] = '0; h_adc[1] = '0; h_set[0] = '0; h_set[1] = '0;
            m_sh[0] = 8'd94; m_sh[1] = 8'd0; m_sh[2] = 8'hA3; m_sh[3] = 8'd0; m_sh[4] = 8'hC0;
            for (int i = 0; i < 5; i++) m_act[i] = m_sh[i];
        end else begin
            bnd   = m_run && ena && ((m_t % N) == N - 2);
            stp   = m_run && ena && ((m_t % N) == N - 1);
            apply = m_pend && (bnd || !m_run);
            if (bnd) begin
                m_adc = h_adc[1];
                m_set = h_set[1];
            end
            m_step = stp;
            if (apply) for (int i = 0; i < 5; i++) m_act[i] = m_sh[i];
            if (cfg_valid_i && !m_pend) begin
                if (cfg_addr_i < 3'd5) m_sh[cfg_addr_i] = cfg_data_i;
                else                   m_err = 1;
            end
            new_pend = apply ? 1'b0 : (m_pend || cfg_commit_i);
            m_pend = new_pend;
            if (m_run && ena) m_t++;
            else if (!m_run && ena) begin m_run = 1; m_t = 0; end
            else begin m_run = 0; m_t = 0; end
            h_adc[1] = h_adc[0]; h_adc[0] = adc_i;
            h_set[1] = h_set[0]; h_set[0] = set_i;
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        cfg_valid_i = 0; cfg_commit_i = 0; cfg_addr_i = '0; cfg_data_i = '0;
    endtask

    task automatic do_reset(input logic [3:0] a, input logic [3:0] s);
        rst_n = 0; ena = 0; adc_i = a; set_i = s;
        idle_inputs();
        tick(); tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0; ena = 1; adc_i = 4'hF; set_i = 4'hF;
        cfg_valid_i = 1; cfg_addr_i = 3'd0; cfg_data_i = 8'h33; cfg_commit_i = 1;
        tick(); tick();
        total_cnt++;
        if (dut_vec !== RESET_VEC) $display("FAIL reset_values: got %h want %h", dut_vec, RESET_VEC);
        else pass_cnt++;
        total_cnt++;
        if (dut_vec !== exp_vec()) $display("FAIL reset_model: got %h want %h", dut_vec, exp_vec());
        else pass_cnt++;
        rst_n = 1; ena = 0; idle_inputs();
    endtask

    task automatic test_step_timing();
        do_reset(4'd5, 4'd9);
        ena = 1;
        tick();
        for (int c = 1; c <= 30; c++) begin
            tick();
            total_cnt++;
            if (step_o !== 1'((c % N) == 0)) $display("FAIL step_timing c=%0d: got %b want %b", c, step_o, (c % N) == 0);
            else pass_cnt++;
            total_cnt++;
            if (adc_o !== ((c >= 9) ? 4'd5 : 4'd0) || set_o !== ((c >= 9) ? 4'd9 : 4'd0))
                $display("FAIL sample_timing c=%0d: got adc %0d set %0d", c, adc_o, set_o);
            else pass_cnt++;
            total_cnt++;
            if (dut_vec !== exp_vec()) $display("FAIL step_model c=%0d: got %h want %h", c, dut_vec, exp_vec());
            else pass_cnt++;
        end
    endtask

    task automatic test_commit();
        do_reset(4'd0, 4'd0);
        ena = 1;
        tick();
        for (int c = 1; c <= 12; c++) begin
            cfg_valid_i = (c == 2); cfg_addr_i = 3'd0; cfg_data_i = 8'h40;
            cfg_commit_i = (c == 4);
            tick();
            total_cnt++;
            if (dut_vec !== exp_vec()) $display("FAIL commit_model c=%0d: got %h want %h", c, dut_vec, exp_vec());
            else pass_cnt++;
            if (c == 8) begin
                total_cnt++;
                if (cfg_ready_o !== 1'b0 || b2_o !== 8'h5E) $display("FAIL commit_before c=8: got ready %b b2 %h want 0 5e", cfg_ready_o, b2_o);
                else pass_cnt++;
            end
            if (c == 9) begin
                total_cnt++;
                if (b2_o !== 8'h40 || cfg_pending_o !== 1'b0 || cfg_ready_o !== 1'b1)
                    $display("FAIL commit_apply c=9: got b2 %h pend %b ready %b want 40 0 1", b2_o, cfg_pending_o, cfg_ready_o);
                else pass_cnt++;
            end
            if (c == 10) begin
                total_cnt++;
                if (step_o !== 1'b1 || b2_o !== 8'h40) $display("FAIL commit_step c=10: got step %b b2 %h want 1 40", step_o, b2_o);
                else pass_cnt++;
            end
        end
        idle_inputs();
    endtask

    task automatic test_write_with_commit();
        do_reset(4'd0, 4'd0);
        ena = 1;
        tick();
        for (int c = 1; c <= 14; c++) begin
            cfg_valid_i  = (c == 3) || (c == 6);
            cfg_addr_i   = (c == 3) ? 3'd2 : 3'd1;
            cfg_data_i   = (c == 3) ? 8'h11 : 8'h55;
            cfg_commit_i = (c == 3) || (c == 6);
            tick();
            total_cnt++;
            if (dut_vec !== exp_vec()) $display("FAIL wrcommit_model c=%0d: got %h want %h", c, dut_vec, exp_vec());
            else pass_cnt++;
            if (c == 9) begin
                total_cnt++;
                if (b0_o !== 8'h11 || b1_o !== 8'h00 || cfg_pending_o !== 1'b0)
                    $display("FAIL wrcommit_apply: got b0 %h b1 %h pend %b want 11 00 0", b0_o, b1_o, cfg_pending_o);
                else pass_cnt++;
            end
            if (c == 12) begin
                total_cnt++;
                if (cfg_pending_o !== 1'b0) $display("FAIL second_commit_ignored: got pend %b want 0", cfg_pending_o);
                else pass_cnt++;
            end
        end
        idle_inputs();
    endtask

    task automatic test_bad_addr();
        do_reset(4'd0, 4'd0);
        ena = 0;
        for (int c = 1; c <= 8; c++) begin
            cfg_valid_i = (c == 2); cfg_addr_i = 3'd6; cfg_data_i = 8'hFF;
            cfg_commit_i = (c == 4);
            tick();
            total_cnt++;
            if (dut_vec !== exp_vec()) $display("FAIL badaddr_model c=%0d: got %h want %h", c, dut_vec, exp_vec());
            else pass_cnt++;
            if (c >= 2) begin
                total_cnt++;
                if (cfg_err_o !== 1'b1) $display("FAIL badaddr_err c=%0d: got %b want 1", c, cfg_err_o);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if ({b2_o, b1_o, b0_o, a1_o, a0_o} !== 40'h5E00A300C0)
            $display("FAIL badaddr_coefs: got %h want 5e00a300c0", {b2_o, b1_o, b0_o, a1_o, a0_o});
        else pass_cnt++;
        do_reset(4'd0, 4'd0);
        total_cnt++;
        if (cfg_err_o !== 1'b0) $display("FAIL badaddr_clear: got %b want 0", cfg_err_o);
        else pass_cnt++;
    endtask

    task automatic test_ena_drop();
        do_reset(4'd5, 4'd9);
        ena = 1;
        tick();
        for (int c = 1; c <= 34; c++) begin
            ena = !(c >= 18 && c <= 22);
            if (c == 12) adc_i = 4'd3;
            tick();
            total_cnt++;
            if (dut_vec !== exp_vec()) $display("FAIL enadrop_model c=%0d: got %h want %h", c, dut_vec, exp_vec());
            else pass_cnt++;
            if (c >= 18 && c <= 32) begin
                total_cnt++;
                if (step_o !== 1'b0) $display("FAIL enadrop_nostep c=%0d: got %b want 0", c, step_o);
                else pass_cnt++;
            end
            if (c >= 10 && c <= 31) begin
                total_cnt++;
                if (adc_o !== 4'd5) $display("FAIL enadrop_hold c=%0d: got %0d want 5", c, adc_o);
                else pass_cnt++;
            end
            if (c == 33) begin
                total_cnt++;
                if (step_o !== 1'b1 || adc_o !== 4'd3) $display("FAIL enadrop_restart: got step %b adc %0d want 1 3", step_o, adc_o);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset(4'd7, 4'd2);
        ena = 1;
        tick();
        for (int c = 1; c <= 6; c++) begin
            cfg_valid_i = (c == 2); cfg_addr_i = 3'd3; cfg_data_i = 8'h77;
            cfg_commit_i = (c == 2);
            tick();
        end
        total_cnt++;
        if (cfg_pending_o !== 1'b1) $display("FAIL resetmid_pending: got %b want 1", cfg_pending_o);
        else pass_cnt++;
        rst_n = 0; cfg_valid_i = 1; cfg_addr_i = 3'd4; cfg_data_i = 8'h12; cfg_commit_i = 1;
        tick();
        total_cnt++;
        if (dut_vec !== RESET_VEC) $display("FAIL resetmid_values: got %h want %h", dut_vec, RESET_VEC);
        else pass_cnt++;
        rst_n = 1; idle_inputs();
    endtask

    task automatic test_random();
        do_reset(4'd0, 4'd0);
        for (int c = 0; c < 800; c++) begin
            rst_n        = ($urandom_range(0, 149) != 0);
            ena          = ($urandom_range(0, 24) != 0);
            adc_i        = 4'($urandom_range(0, 15));
            set_i        = 4'($urandom_range(0, 15));
            cfg_valid_i  = ($urandom_range(0, 3) == 0);
            cfg_addr_i   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            cfg_data_i   = 8'($urandom_range(0, 255));
            cfg_commit_i = ($urandom_range(0, 5) == 0);
            tick();
            total_cnt++;
            if (dut_vec !== exp_vec()) $display("FAIL random_model c=%0d: got %h want %h", c, dut_vec, exp_vec());
            else pass_cnt++;
        end
        rst_n = 1; idle_inputs();
    endtask

    initial begin
        test_reset();
        test_step_timing();
        test_commit();
        test_write_with_commit();
        test_bad_addr();
        test_ena_drop();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fan_step_scheduler.md
FAN_STEP_SCHEDULER -- requirements
Module: fan_step_scheduler

Interface
REQ-001 Parameter STEP_CYCLES, default 200000: clk cycles per controller time step (200 ms at 1 MHz); legal range 4..2^18-1.
REQ-002 Parameter ADC_BITWIDTH, default 4: width of the sampled ADC and SET values.
REQ-003 Parameter COEF_BITWIDTH, default 8: width of each signed coefficient.
REQ-004 Parameters RST_B2/RST_B1/RST_B0/RST_A1/RST_A0, defaults 94/0/-93/0/-64: coefficient reset values.
REQ-005 clk  in  1  system clock; the only clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  synchronous, active-low reset.
REQ-007 ena  in  1  run enable; low forces IDLE.
REQ-008 adc_i  in  ADC_BITWIDTH  raw ADC value, asynchronous to clk.
REQ-009 set_i  in  ADC_BITWIDTH  raw set-point value, asynchronous to clk.
REQ-010 cfg_valid_i  in  1  coefficient write request.
REQ-011 cfg_addr_i  in  3  0=b2, 1=b1, 2=b0, 3=a1, 4=a0; 5..7 invalid.
REQ-012 cfg_data_i  in  COEF_BITWIDTH  coefficient write data.
REQ-013 cfg_commit_i  in  1  request to apply the shadow set at the next step boundary.
REQ-014 cfg_ready_o  out  1  write accepted when cfg_valid_i & cfg_ready_o are both high.
REQ-015 cfg_pending_o  out  1  commit requested, not yet applied.
REQ-016 cfg_err_o  out  1  sticky: invalid address written.
REQ-017 step_o  out  1  one-cycle clock-enable pulse to the controller datapath.
REQ-018 adc_o, set_o  out  ADC_BITWIDTH each  held samples presented to the controller.
REQ-019 b2_o, b1_o, b0_o, a1_o, a0_o  out  COEF_BITWIDTH each  active coefficient set.

Function
REQ-020 adc_i and set_i SHALL each pass through a 2-flop synchronizer; only synchronized values are sampled.
REQ-021 FSM states: IDLE, RUN; IDLE->RUN when ena=1; RUN->IDLE when ena=0, in the same cycle ena is seen low.
REQ-022 In IDLE the step counter SHALL be 0 and step_o SHALL be 0; adc_o, set_o and the active coefficients hold.
REQ-023 In RUN the counter SHALL count 0..STEP_CYCLES-1 and wrap to 0.
REQ-024 At count==STEP_CYCLES-2: adc_o and set_o load the synchronized values; if pending, the active set loads from the shadow set and pending clears.
REQ-025 At count==STEP_CYCLES-1: step_o=1 for exactly one cycle; the first step_o after IDLE->RUN occurs STEP_CYCLES cycles after entry.
REQ-026 Outputs adc_o, set_o and b*_o/a*_o SHALL NOT change except at the REQ-024 cycle, in IDLE per REQ-029, or on reset.
REQ-027 cfg_ready_o = !cfg_pending_o; an accepted write updates shadow[cfg_addr_i] on the next edge; addresses 5..7 are accepted, set cfg_err_o and change nothing.
REQ-028 cfg_commit_i while not pending sets pending; while pending it is ignored; a write and a commit in the same cycle SHALL both take effect, and the write is included in the applied set.
REQ-029 In IDLE a pending commit SHALL be applied on the following edge, since no step is in flight.
REQ-030 ena dropping mid-period SHALL abort the period: counter cleared, no step_o, samples not updated, pending preserved.
REQ-031 Coefficients are opaque two's-complement bit patterns; no saturation or arithmetic is performed on them.

Reset
REQ-032 With rst_n=0 at a clock edge: state=IDLE, counter=0, step_o=0, adc_o=set_o=0, synchronizers=0, pending=0, cfg_err_o=0, cfg_ready_o=1; shadow and active sets = RST_* values (b2_o=94, b0_o=-93=8'hA3, a0_o=-64=8'hC0).
REQ-033 Reset SHALL override all other inputs, including a simultaneous cfg write or commit.

Verification (STEP_CYCLES=10)
REQ-034 Reset, ena=1, adc_i=5, set_i=9 -> step_o pulses at cycles 10, 20, 30 after entry; adc_o=5 and set_o=9 from cycle 9.
REQ-035 Write addr0=0x40, commit at cycle 3 -> cfg_ready_o=0 until cycle 9, when b2_o=0x40 and pending clears; step at cycle 10 sees the new b2_o.
REQ-036 Write addr2=0x11 together with commit -> b0_o=0x11 at the next boundary; a second commit while pending -> no effect.
REQ-037 Write addr 6 -> cfg_err_o=1 and stays 1; all shadow and active values unchanged; cleared only by rst_n.
REQ-038 ena=0 at cycle 7 -> no step_o, counter=0, adc_o unchanged; ena=1 again -> first step_o 10 cycles later.
REQ-039 rst_n=0 mid-period while pending -> all outputs at REQ-032 values on the next edge; no step_o.
